// File: rtl/riscv_rf_wb_arbiter_if.sv
// Writeback request bus between the EX/WB producers and the RF write arbiter.
// Each requester owns one lane of every vector. A lane holds valid/addr/data/tag
// stable until it sees ready. The handshake completes on valid & ready.
interface riscv_rf_wb_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_tag;
  logic [NUM_REQ-1:0]                 req_ready;

  // producer side
  modport master (output req_valid, req_addr, req_data, req_tag, input req_ready);
  // arbiter side
  modport slave  (input req_valid, req_addr, req_data, req_tag, output req_ready);
endinterface

// File: rtl/riscv_rf_wb_arbiter.sv
// Register-file writeback arbiter. It grants up to two producers per cycle in
// round-robin order onto RF write ports A and B through a one-cycle registered
// stage. It also flags read ports whose address matches a write still staged.
module riscv_rf_wb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hold_i,
  riscv_rf_wb_arbiter_if.slave       req_if,
  output logic [ADDR_WIDTH-1:0]      waddr_a_o,
  output logic [DATA_WIDTH-1:0]      wdata_a_o,
  output logic                       wtag_a_o,
  output logic                       we_a_o,
  output logic [ADDR_WIDTH-1:0]      waddr_b_o,
  output logic [DATA_WIDTH-1:0]      wdata_b_o,
  output logic                       wtag_b_o,
  output logic                       we_b_o,
  input  logic [2:0][ADDR_WIDTH-1:0] chk_addr_i,
  output logic [2:0]                 hazard_o
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  a_vld, b_vld;
  logic [PW-1:0]         a_idx, b_idx;
  logic                  grant_a, grant_b;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;

  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_b_q;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q;
  logic                  wtag_a_q, wtag_b_q;
  logic                  we_a_q, we_b_q;

  // Round-robin scan starting at rr_ptr. The first valid lane wins port A.
  // The next valid lane whose address differs from A's wins port B.
  always_comb begin
    logic [PW:0] scan_idx;
    a_vld    = 1'b0;
    b_vld    = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (scan_idx >= (PW+1)'(NUM_REQ)) scan_idx = scan_idx - (PW+1)'(NUM_REQ);
      if (req_if.req_valid[scan_idx[PW-1:0]]) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = scan_idx[PW-1:0];
        end else if (!b_vld &&
                     req_if.req_addr[scan_idx[PW-1:0]] != req_if.req_addr[a_idx]) begin
          b_vld = 1'b1;
          b_idx = scan_idx[PW-1:0];
        end
      end
    end
  end

  // Hold and reset both suppress grants, so ready is never raised without a
  // grant that the write stage will act on.
  assign grant_a = a_vld & ~hold_i & rst_n;
  assign grant_b = b_vld & ~hold_i & rst_n;
  assign a_addr  = req_if.req_addr[a_idx];
  assign b_addr  = req_if.req_addr[b_idx];

  // Ready goes to the winning lanes only. A winner is valid by construction.
  always_comb begin
    req_if.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_if.req_ready[i] = (grant_a && a_idx == PW'(i)) || (grant_b && b_idx == PW'(i));
    end
  end

  // Next scan starts just after the last lane granted this cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_b) begin
      rr_ptr_d = (b_idx == PW'(NUM_REQ-1)) ? '0 : b_idx + 1'b1;
    end else if (grant_a) begin
      rr_ptr_d = (a_idx == PW'(NUM_REQ-1)) ? '0 : a_idx + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  // Write stage for port A. An x0 grant consumes the slot but writes nothing.
  // Addr/data/tag keep their last values when the port does not write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_a_q    <= 1'b0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
      wtag_a_q  <= 1'b0;
    end else begin
      we_a_q <= grant_a && (a_addr != '0);
      if (grant_a && (a_addr != '0)) begin
        waddr_a_q <= a_addr;
        wdata_a_q <= req_if.req_data[a_idx];
        wtag_a_q  <= req_if.req_tag[a_idx];
      end
    end
  end

  // Write stage for port B. It follows the same rules as port A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_b_q    <= 1'b0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
      wtag_b_q  <= 1'b0;
    end else begin
      we_b_q <= grant_b && (b_addr != '0);
      if (grant_b && (b_addr != '0)) begin
        waddr_b_q <= b_addr;
        wdata_b_q <= req_if.req_data[b_idx];
        wtag_b_q  <= req_if.req_tag[b_idx];
      end
    end
  end

  assign we_a_o    = we_a_q;
  assign waddr_a_o = waddr_a_q;
  assign wdata_a_o = wdata_a_q;
  assign wtag_a_o  = wtag_a_q;
  assign we_b_o    = we_b_q;
  assign waddr_b_o = waddr_b_q;
  assign wdata_b_o = wdata_b_q;
  assign wtag_b_o  = wtag_b_q;

  // Per read port: a staged write to the same non-x0 register has not landed yet.
  for (genvar k = 0; k < 3; k++) begin : g_hazard
    assign hazard_o[k] = (chk_addr_i[k] != '0) &&
                         ((we_a_q && waddr_a_q == chk_addr_i[k]) ||
                          (we_b_q && waddr_b_q == chk_addr_i[k]));
  end

endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// Self-checking bench for riscv_rf_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_riscv_rf_wb_arbiter;
  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic hold;
  logic [2:0][AW-1:0] chk_addr;
  logic [AW-1:0] waddr_a, waddr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic wtag_a, wtag_b, we_a, we_b;
  logic [2:0] hazard;

  riscv_rf_wb_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rif();

  riscv_rf_wb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold), .req_if(rif),
    .waddr_a_o(waddr_a), .wdata_a_o(wdata_a), .wtag_a_o(wtag_a), .we_a_o(we_a),
    .waddr_b_o(waddr_b), .wdata_b_o(wdata_b), .wtag_b_o(wtag_b), .we_b_o(we_b),
    .chk_addr_i(chk_addr), .hazard_o(hazard)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: the round-robin start point and what each RF port should show.
  int            m_rr;
  logic          m_we_a, m_we_b, m_tag_a, m_tag_b;
  logic [AW-1:0] m_addr_a, m_addr_b;
  logic [DW-1:0] m_data_a, m_data_b;
  logic [N-1:0]  g;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_we_a = 0; m_we_b = 0; m_tag_a = 0; m_tag_b = 0;
    m_addr_a = '0; m_addr_b = '0; m_data_a = '0; m_data_b = '0;
  endtask

  // Model the winners. Walk the lanes from the round-robin start. The first
  // valid lane takes port A. The next valid lane with a different address takes port B.
  task automatic model_pick(output int wa, output int wb);
    wa = -1; wb = -1;
    if (hold || !rst_n) return;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (rif.req_valid[i]) begin
        if (wa < 0) wa = i;
        else if (wb < 0 && rif.req_addr[i] != rif.req_addr[wa]) wb = i;
      end
    end
  endtask

  // Run one cycle. This task is called at a negedge with inputs already
  // driven. It compares all outputs to the model, then advances the model at
  // posedge and returns at the next negedge.
  task automatic step(output logic [N-1:0] gr);
    int wa, wb;
    logic [N-1:0] exp_rdy;
    logic [2:0] exp_hz;
    #1;
    model_pick(wa, wb);
    exp_rdy = '0;
    if (wa >= 0) exp_rdy[wa] = 1'b1;
    if (wb >= 0) exp_rdy[wb] = 1'b1;
    for (int k = 0; k < 3; k++)
      exp_hz[k] = (chk_addr[k] != 0) &&
                  ((m_we_a && m_addr_a == chk_addr[k]) || (m_we_b && m_addr_b == chk_addr[k]));
    chk("ready",   64'(rif.req_ready), 64'(exp_rdy));
    chk("we_a",    64'(we_a),    64'(m_we_a));
    chk("we_b",    64'(we_b),    64'(m_we_b));
    chk("waddr_a", 64'(waddr_a), 64'(m_addr_a));
    chk("waddr_b", 64'(waddr_b), 64'(m_addr_b));
    chk("wdata_a", 64'(wdata_a), 64'(m_data_a));
    chk("wdata_b", 64'(wdata_b), 64'(m_data_b));
    chk("wtag_a",  64'(wtag_a),  64'(m_tag_a));
    chk("wtag_b",  64'(wtag_b),  64'(m_tag_b));
    chk("hazard",  64'(hazard),  64'(exp_hz));
    gr = exp_rdy;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      m_we_a = (wa >= 0) && (rif.req_addr[wa] != 0);
      if (m_we_a) begin
        m_addr_a = rif.req_addr[wa]; m_data_a = rif.req_data[wa]; m_tag_a = rif.req_tag[wa];
      end
      m_we_b = (wb >= 0) && (rif.req_addr[wb] != 0);
      if (m_we_b) begin
        m_addr_b = rif.req_addr[wb]; m_data_b = rif.req_data[wb]; m_tag_b = rif.req_tag[wb];
      end
      if (wb >= 0)      m_rr = (wb + 1) % N;
      else if (wa >= 0) m_rr = (wa + 1) % N;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int a, input logic [DW-1:0] d, input logic t);
    rif.req_valid[i] = 1'b1;
    rif.req_addr[i]  = AW'(a);
    rif.req_data[i]  = d;
    rif.req_tag[i]   = t;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rif.req_valid = '0;
    model_reset();
    step(g);
    step(g);
    rst_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? AW'(32) : AW'(r);
  endfunction

  initial begin
    rst_n = 1'b0; hold = 1'b0; chk_addr = '0;
    rif.req_valid = '0; rif.req_addr = '0; rif.req_data = '0; rif.req_tag = '0;
    model_reset();
    // Reset state: outputs are clear, and ready stays low even with requests present.
    #2;
    rif.req_valid = '1;
    #1;
    chk("rst_ready",  64'(rif.req_ready), 64'(0));
    chk("rst_we",     64'({we_a, we_b}), 64'(0));
    chk("rst_hazard", 64'(hazard), 64'(0));
    @(negedge clk);
    do_reset();

    // Scenario 1: a single requester.
    set_req(0, 5, 32'hDEADBEEF, 1'b1);
    #1 chk("t1_ready", 64'(rif.req_ready), 64'(4'b0001));
    step(g);
    rif.req_valid = '0;
    chk("t1_we_a",  64'(we_a), 64'(1));
    chk("t1_addr",  64'(waddr_a), 64'(5));
    chk("t1_data",  64'(wdata_a), 64'(32'hDEADBEEF));
    chk("t1_tag",   64'(wtag_a), 64'(1));
    chk("t1_we_b",  64'(we_b), 64'(0));
    step(g);
    chk("t1_we_a_off", 64'(we_a), 64'(0));

    // Scenario 2: four distinct addresses, two grants per cycle.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, i + 1, DW'(32'h100 + i), 1'b0);
    #1 chk("t2_ready0", 64'(rif.req_ready), 64'(4'b0011));
    step(g);
    chk("t2_a0", 64'(waddr_a), 64'(1));
    chk("t2_b0", 64'(waddr_b), 64'(2));
    rif.req_valid[0] = 1'b0; rif.req_valid[1] = 1'b0;
    #1 chk("t2_ready1", 64'(rif.req_ready), 64'(4'b1100));
    step(g);
    chk("t2_a1", 64'(waddr_a), 64'(3));
    chk("t2_b1", 64'(waddr_b), 64'(4));
    rif.req_valid = '0;

    // Scenario 3: an address conflict stalls the second requester to addr 7.
    do_reset();
    set_req(0, 10, 32'h0, 1'b0);
    step(g);
    rif.req_valid = '0;
    set_req(1, 7, 32'h71, 1'b0);
    set_req(2, 7, 32'h72, 1'b1);
    set_req(3, 9, 32'h93, 1'b0);
    #1 chk("t3_ready0", 64'(rif.req_ready), 64'(4'b1010));
    step(g);
    chk("t3_a0", 64'(waddr_a), 64'(7));
    chk("t3_b0", 64'(waddr_b), 64'(9));
    rif.req_valid[1] = 1'b0; rif.req_valid[3] = 1'b0;
    #1 chk("t3_ready1", 64'(rif.req_ready), 64'(4'b0100));
    step(g);
    chk("t3_a1",    64'(waddr_a), 64'(7));
    chk("t3_d1",    64'(wdata_a), 64'(32'h72));
    chk("t3_we_b1", 64'(we_b), 64'(0));
    rif.req_valid = '0;

    // Scenario 4: an x0 write is dropped but still advances the pointer. f0 is writable.
    do_reset();
    set_req(0, 0, 32'h1234, 1'b0);
    #1 chk("t4_ready0", 64'(rif.req_ready), 64'(4'b0001));
    step(g);
    chk("t4_we_a0", 64'(we_a), 64'(0));
    set_req(0, 32, 32'hF0F0, 1'b0);
    set_req(1, 40, 32'h4040, 1'b1);
    step(g);
    rif.req_valid = '0;
    chk("t4_a_rr",  64'(waddr_a), 64'(40));
    chk("t4_b_f0",  64'(waddr_b), 64'(32));
    chk("t4_we_b",  64'(we_b), 64'(1));

    // Scenario 5: hold blocks grants and writes. The grant happens as soon as hold drops.
    hold = 1'b1;
    set_req(2, 3, 32'h333, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1 chk("t5_hold_ready", 64'(rif.req_ready), 64'(0));
      step(g);
      chk("t5_hold_we", 64'({we_a, we_b}), 64'(0));
    end
    hold = 1'b0;
    #1 chk("t5_ready", 64'(rif.req_ready), 64'(4'b0100));
    step(g);
    rif.req_valid = '0;
    chk("t5_we_a", 64'(we_a), 64'(1));
    chk("t5_addr", 64'(waddr_a), 64'(3));

    // Scenario 6: a hazard on a staged port-B write, then an asynchronous reset mid-cycle.
    set_req(0, 20, 32'h20, 1'b0);
    set_req(1, 12, 32'h12, 1'b1);
    chk_addr[0] = 6'd12; chk_addr[1] = 6'd0; chk_addr[2] = 6'd13;
    step(g);
    chk("t6_we_b",   64'(we_b), 64'(1));
    chk("t6_addr_b", 64'(waddr_b), 64'(12));
    chk("t6_hazard", 64'(hazard), 64'(3'b001));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_we_b",   64'(we_b), 64'(0));
    chk("t6_rst_we_a",   64'(we_a), 64'(0));
    chk("t6_rst_hazard", 64'(hazard), 64'(0));
    chk("t6_rst_ready",  64'(rif.req_ready), 64'(0));
    model_reset();
    rif.req_valid = '0;
    @(negedge clk);
    step(g);
    rst_n = 1'b1;

    // Randomized traffic. Un-granted requests are held stable. Granted lanes
    // may issue a new request or go idle.
    g = '0;
    for (int c = 0; c < 3000; c++) begin
      hold = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        if (g[i] || !rif.req_valid[i]) begin
          if ($urandom_range(0, 99) < 60)
            set_req(i, int'(rand_addr()), DW'($urandom), 1'($urandom_range(0, 1)));
          else
            rif.req_valid[i] = 1'b0;
        end
      end
      for (int k = 0; k < 3; k++) chk_addr[k] = rand_addr();
      step(g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
